dmem_ws: RTL and testbench
==========================

DMEM_WS -- requirements
Module: dmem_ws

Interface
REQ-001 SHALL have parameter DW, default 16, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 8, word-address width.
REQ-003 SHALL have parameter DEPTH, default 256, implemented words (1..2^AW).
REQ-004 SHALL have parameter LAT, default 1, wait states per access (0..15).
REQ-005 SHALL have parameters INIT0..INIT3, defaults 16'h0020, 16'h2021, 0, 0, reset contents of words 0..3 (DW bits).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-008 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-009 SHALL have port we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port addr  input  AW  word address.
REQ-011 SHALL have port be  input  DW/8  byte-lane write enables; be[0] = bits 7:0.
REQ-012 SHALL have port wdata  input  DW  write data.
REQ-013 SHALL have port rdata  output  DW  registered read data.
REQ-014 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  completion with addr >= DEPTH; valid only while ack=1.
REQ-016 SHALL have port busy  output  1  1 in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACCESS.
REQ-018 IDLE, req=1: SHALL capture we/addr/be/wdata, load wait counter with LAT, go to WAIT if LAT>0, else ACCESS.
REQ-019 WAIT: SHALL decrement counter each cycle; at counter=1, go to ACCESS (LAT wait cycles total).
REQ-020 ACCESS: SHALL perform the access with captured values, assert ack=1 for exactly that one cycle, return to IDLE.
REQ-021 Latency: ack SHALL assert LAT+1 cycles after the clock edge that samples req.
REQ-022 Write, in range: SHALL update only byte lanes with be=1; be=0 lanes unchanged; be all-zero = no change, ack still given.
REQ-023 Read, in range: rdata SHALL load mem[addr] in the ACCESS cycle (visible with ack) and hold until the next read completion.
REQ-024 addr >= DEPTH: no memory write; a read SHALL load rdata=0; err=1 with ack.
REQ-025 req, we, addr, be, wdata SHALL be ignored while busy=1; captured values SHALL NOT change mid-access.
REQ-026 req held high SHALL start a new access on the cycle after ack (back-to-back: one IDLE cycle between accesses).
REQ-027 Read-after-write to the same word SHALL return the written data.
REQ-028 err SHALL be 0 whenever ack=0.

Reset
REQ-029 rst=0 SHALL force immediately: state IDLE, counter 0, ack=0, err=0, busy=0, rdata=0.
REQ-030 rst=0 SHALL load words 0..3 with INIT0..INIT3; words 4..DEPTH-1 SHALL keep their contents.
REQ-031 Reset during WAIT or ACCESS SHALL abort the access: no write, no ack after rst deasserts.
REQ-032 First req SHALL be sampled on the first rising clk edge with rst=1.

Verification
REQ-033 Reset, LAT=1, read addr 1 -> ack on 2nd cycle after sampling, rdata=16'h2021, err=0.
REQ-034 Write addr 5 = 16'hABCD with be=2'b11, then be=2'b01 with wdata 16'h0012, read addr 5 -> 16'hAB12.
REQ-035 LAT=0 and LAT=3 builds: read latency = 1 and 4 cycles; busy high from the cycle after sampling until ack.
REQ-036 DEPTH=200, read addr 8'd250 -> ack with err=1, rdata=0; write to 250 leaves all memory unchanged.
REQ-037 Write addr 2 = 16'h1234, assert rst during WAIT -> no ack; read addr 2 -> 16'h0000 (INIT2).
REQ-038 req held high with changing addr during busy -> only the sampled addresses are accessed; acks separated by LAT+1 idle/wait cycles.

Source files
------------

// File: rtl/dmem_ws_if.sv
// Request/response bus for the wait-state data memory.
interface dmem_ws_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) ();
  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            ack;
  logic            err;
  logic            busy;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/dmem_ws.sv
// Word-addressed data memory with byte-lane writes and a programmable number of
// wait states. Words 0..3 reload their init values on reset; the rest retain contents.
module dmem_ws #(
  parameter int unsigned   DW    = 16,
  parameter int unsigned   AW    = 8,
  parameter int unsigned   DEPTH = 256,
  parameter int unsigned   LAT   = 1,
  parameter logic [DW-1:0] INIT0 = 16'h0020,
  parameter logic [DW-1:0] INIT1 = 16'h2021,
  parameter logic [DW-1:0] INIT2 = '0,
  parameter logic [DW-1:0] INIT3 = '0
) (
  input logic      clk,
  input logic      rst,
  dmem_ws_if.slave bus
);
  localparam int unsigned NB = DW / 8;
  localparam logic [DW-1:0] InitTbl [4] = '{INIT0, INIT1, INIT2, INIT3};

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            w_capture;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [NB-1:0]   r_be;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_ack;
  logic            r_err;
  logic            w_in_range;
  logic            w_do_access;
  logic            w_wr;
  logic [DW-1:0]   w_rd_word;
  logic [DW-1:0]   w_merged;
  logic [DW-1:0]   w_mem [DEPTH];

  // Next-state and wait-counter logic; requests are only looked at in idle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.req) begin
          w_capture    = 1'b1;
          w_cnt_next   = 4'(LAT);
          w_state_next = (LAT > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = StAccess;
      end
      StAccess: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request capture; held stable for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_be    <= bus.be;
      r_wdata <= bus.wdata;
    end
  end

  assign w_in_range  = (32'(r_addr) < DEPTH);
  assign w_do_access = (r_state == StAccess);
  assign w_wr        = w_do_access && r_we && w_in_range;
  assign w_rd_word   = w_in_range ? w_mem[r_addr] : '0;

  // Read-modify-write merge of the enabled byte lanes.
  always_comb begin
    w_merged = w_rd_word;
    for (int b = 0; b < NB; b++) begin
      if (r_be[b]) w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DW-1:0] r_word;
    logic          w_sel;
    assign w_sel = w_wr && (32'(r_addr) == g);
    if (g < 4) begin : g_init
      // Low words reload their init value on reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_word <= InitTbl[g];
        else if (w_sel) r_word <= w_merged;
      end
    end else begin : g_plain
      // Remaining words are not touched by reset.
      always_ff @(posedge clk) begin
        if (w_sel) r_word <= w_merged;
      end
    end
    assign w_mem[g] = r_word;
  end

  // Completion: ack/err pulse for one cycle, read data held until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_do_access;
      r_err <= w_do_access && !w_in_range;
      if (w_do_access && !r_we) r_rdata <= w_rd_word;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.busy  = (r_state != StIdle);
endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: three builds (LAT=1, LAT=0, LAT=3/DEPTH=200) share the request
// fields and are compared against a per-build array model of the memory.
module tb_dmem_ws;
  localparam int DEPTHS [3] = '{256, 256, 200};
  localparam int LATS   [3] = '{1, 0, 3};
  localparam logic [15:0] INITS [4] = '{16'h0020, 16'h2021, 16'h0000, 16'h0000};

  logic        clk;
  logic        rst;
  logic [2:0]  req_v;
  logic        we_v;
  logic [7:0]  addr_v;
  logic [1:0]  be_v;
  logic [15:0] wdata_v;

  logic        o_ack   [3];
  logic        o_err   [3];
  logic        o_busy  [3];
  logic [15:0] o_rdata [3];

  logic [15:0] mdl    [3][256];
  logic [15:0] exp_rd [3];
  int n_pass;
  int n_total;

  dmem_ws_if #(.DW(16), .AW(8)) bus0 ();
  dmem_ws_if #(.DW(16), .AW(8)) bus1 ();
  dmem_ws_if #(.DW(16), .AW(8)) bus2 ();

  dmem_ws #(.DW(16), .AW(8), .DEPTH(256), .LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_ws #(.DW(16), .AW(8), .DEPTH(256), .LAT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_ws #(.DW(16), .AW(8), .DEPTH(200), .LAT(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.req = req_v[0];
  assign bus1.req = req_v[1];
  assign bus2.req = req_v[2];
  assign bus0.we = we_v;      assign bus1.we = we_v;      assign bus2.we = we_v;
  assign bus0.addr = addr_v;  assign bus1.addr = addr_v;  assign bus2.addr = addr_v;
  assign bus0.be = be_v;      assign bus1.be = be_v;      assign bus2.be = be_v;
  assign bus0.wdata = wdata_v; assign bus1.wdata = wdata_v; assign bus2.wdata = wdata_v;
  assign o_ack[0] = bus0.ack;   assign o_ack[1] = bus1.ack;   assign o_ack[2] = bus2.ack;
  assign o_err[0] = bus0.err;   assign o_err[1] = bus1.err;   assign o_err[2] = bus2.err;
  assign o_busy[0] = bus0.busy; assign o_busy[1] = bus1.busy; assign o_busy[2] = bus2.busy;
  assign o_rdata[0] = bus0.rdata; assign o_rdata[1] = bus1.rdata; assign o_rdata[2] = bus2.rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] b);
    logic [15:0] r;
    r = old;
    if (b[0]) r[7:0] = d[7:0];
    if (b[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Apply one access to the model of build k.
  task automatic model_access(input int k, input bit w, input logic [7:0] a,
                              input logic [1:0] b, input logic [15:0] d);
    if (int'(a) < DEPTHS[k]) begin
      if (w) mdl[k][a] = merge(mdl[k][a], d, b);
      else   exp_rd[k] = mdl[k][a];
    end else if (!w) begin
      exp_rd[k] = 16'h0000;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) mdl[k][i] = INITS[i];
      exp_rd[k] = 16'h0000;
    end
  endtask

  // One access on all three builds; checks latency, busy, err and rdata of each.
  task automatic do_access(input bit w, input logic [7:0] a, input logic [1:0] b,
                           input logic [15:0] d, input bit sync);
    int          ack_at [3];
    int          nack   [3];
    logic [15:0] rd_at  [3];
    logic        er_at  [3];
    bit          flags_ok [3];
    if (sync) @(negedge clk);
    we_v = w; addr_v = a; be_v = b; wdata_v = d; req_v = 3'b111;
    for (int k = 0; k < 3; k++) begin
      model_access(k, w, a, b, d);
      ack_at[k] = -1; nack[k] = 0; rd_at[k] = 16'hxxxx; er_at[k] = 1'bx; flags_ok[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    // Scramble inputs mid-access: the captured request must be used.
    req_v = 3'b000;
    we_v = 1'($urandom); addr_v = 8'($urandom); be_v = 2'($urandom); wdata_v = 16'($urandom);
    for (int n = 0; n < 7; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 3; k++) begin
        if (o_ack[k] === 1'b1) begin
          nack[k]++; ack_at[k] = n; rd_at[k] = o_rdata[k]; er_at[k] = o_err[k];
        end else if (o_err[k] !== 1'b0) begin
          flags_ok[k] = 1'b0;
        end
        if (n <= LATS[k] && o_busy[k] !== 1'b1) flags_ok[k] = 1'b0;
        if (n > LATS[k] && o_busy[k] !== 1'b0) flags_ok[k] = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (nack[k] != 1 || ack_at[k] != LATS[k] + 1)
        $display("FAIL latency dut%0d addr %0d: acks %0d at cycle %0d, want 1 at %0d",
                 k, a, nack[k], ack_at[k], LATS[k] + 1);
      else n_pass++;
      n_total++;
      if (rd_at[k] !== exp_rd[k])
        $display("FAIL rdata dut%0d addr %0d we %0d: got %h want %h", k, a, w, rd_at[k], exp_rd[k]);
      else n_pass++;
      n_total++;
      if (er_at[k] !== (int'(a) >= DEPTHS[k]))
        $display("FAIL err dut%0d addr %0d: got %b want %b", k, a, er_at[k], int'(a) >= DEPTHS[k]);
      else n_pass++;
      n_total++;
      if (!flags_ok[k]) $display("FAIL busy_err_idle dut%0d addr %0d: got bad want clean", k, a);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_v = 3'b000; we_v = 1'b0; addr_v = '0; be_v = '0; wdata_v = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({o_ack[k], o_err[k], o_busy[k]} !== 3'b000)
        $display("FAIL reset_flags dut%0d: got %b want 000", k, {o_ack[k], o_err[k], o_busy[k]});
      else n_pass++;
      n_total++;
      if (o_rdata[k] !== 16'h0000)
        $display("FAIL reset_rdata dut%0d: got %h want 0000", k, o_rdata[k]);
      else n_pass++;
    end
    // Release at a falling edge and request at once: the first rising edge samples it.
    rst = 1'b1;
    do_access(1'b0, 8'd1, 2'b00, 16'h0000, 1'b0);
    n_total++;
    if (o_rdata[0] !== 16'h2021) $display("FAIL init1_read: got %h want 2021", o_rdata[0]);
    else n_pass++;
    for (int i = 0; i < 4; i++) do_access(1'b0, 8'(i), 2'b00, 16'h0000, 1'b1);
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) do_access(1'b1, 8'(a), 2'b11, 16'($urandom), 1'b1);
  endtask

  task automatic test_byte_lanes();
    do_access(1'b1, 8'd5, 2'b11, 16'hABCD, 1'b1);
    do_access(1'b1, 8'd5, 2'b01, 16'h0012, 1'b1);
    do_access(1'b1, 8'd5, 2'b00, 16'hFFFF, 1'b1);
    do_access(1'b0, 8'd5, 2'b00, 16'h0000, 1'b1);
    n_total++;
    if (o_rdata[0] !== 16'hAB12) $display("FAIL byte_lanes: got %h want AB12", o_rdata[0]);
    else n_pass++;
    do_access(1'b1, 8'd6, 2'b10, 16'h5A00, 1'b1);
    do_access(1'b0, 8'd6, 2'b00, 16'h0000, 1'b1);
  endtask

  task automatic test_out_of_range();
    do_access(1'b0, 8'd7, 2'b00, 16'h0000, 1'b1);
    do_access(1'b0, 8'd250, 2'b00, 16'h0000, 1'b1);
    n_total++;
    if (o_rdata[2] !== 16'h0000) $display("FAIL oor_read_hold: got %h want 0000", o_rdata[2]);
    else n_pass++;
    do_access(1'b1, 8'd250, 2'b11, 16'hDEAD, 1'b1);
    do_access(1'b1, 8'd200, 2'b11, 16'hBEEF, 1'b1);
    do_access(1'b0, 8'd199, 2'b00, 16'h0000, 1'b1);
    do_access(1'b0, 8'd250, 2'b00, 16'h0000, 1'b1);
    for (int i = 0; i < 8; i++) do_access(1'b0, 8'(192 + i), 2'b00, 16'h0000, 1'b1);
    do_access(1'b0, 8'd72, 2'b00, 16'h0000, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      do_access(1'($urandom), 8'($urandom), 2'($urandom), 16'($urandom), 1'b1);
  endtask

  task automatic test_reset_abort();
    int acks [3];
    @(negedge clk);
    we_v = 1'b1; addr_v = 8'd2; be_v = 2'b11; wdata_v = 16'h1234; req_v = 3'b111;
    @(posedge clk);
    #1;
    req_v = 3'b000;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({o_ack[k], o_busy[k], o_err[k]} !== 3'b000)
        $display("FAIL abort_flags dut%0d: got %b want 000", k, {o_ack[k], o_busy[k], o_err[k]});
      else n_pass++;
      acks[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (o_ack[k] !== 1'b0) acks[k]++;
    end
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (acks[k] != 0) $display("FAIL abort_no_ack dut%0d: got %0d acks want 0", k, acks[k]);
      else n_pass++;
    end
    do_access(1'b0, 8'd2, 2'b00, 16'h0000, 1'b1);
    n_total++;
    if (o_rdata[0] !== 16'h0000) $display("FAIL abort_word2: got %h want 0000", o_rdata[0]);
    else n_pass++;
    do_access(1'b0, 8'd5, 2'b00, 16'h0000, 1'b1);
    do_access(1'b0, 8'd1, 2'b00, 16'h0000, 1'b1);
  endtask

  // Only build 0 sees req held high; inputs change every cycle, accesses every LAT+2.
  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    logic [15:0] e;
    bit          exp_ack;
    @(negedge clk);
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) @(negedge clk);
      we_v = 1'($urandom); addr_v = 8'($urandom); be_v = 2'($urandom); wdata_v = 16'($urandom);
      req_v = {2'b00, (c <= 23)};
      if (c % 3 == 0 && c <= 23) begin
        model_access(0, we_v, addr_v, be_v, wdata_v);
        exp_q.push_back(exp_rd[0]);
      end
      @(posedge clk);
      #1;
      exp_ack = (c % 3 == 2) && (c <= 23);
      n_total++;
      if (o_ack[0] !== exp_ack) $display("FAIL b2b_ack c%0d: got %b want %b", c, o_ack[0], exp_ack);
      else n_pass++;
      if (exp_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (o_rdata[0] !== e) $display("FAIL b2b_rdata c%0d: got %h want %h", c, o_rdata[0], e);
        else n_pass++;
        n_total++;
        if (o_err[0] !== 1'b0) $display("FAIL b2b_err c%0d: got %b want 0", c, o_err[0]);
        else n_pass++;
      end
    end
    req_v = 3'b000;
    for (int i = 0; i < 6; i++) do_access(1'b0, 8'($urandom), 2'b00, 16'h0000, 1'b1);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fill();
    test_byte_lanes();
    test_out_of_range();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
